// File: rtl/ternary_add_compare_unit_pkg.sv
// Shared trit encoding, default width and trit decode helper for the ternary add/compare unit.
// Encoding: 00 = 0, 01 = +1, 10 = -1; 11 is invalid and decodes as 0.
package ternary_add_compare_unit_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;

  localparam int DEFAULT_WORD_SIZE = 9;

  function automatic int trit_to_int(input logic [1:0] t);
    case (t)
      TRIT_POS: trit_to_int = 1;
      TRIT_NEG: trit_to_int = -1;
      default:  trit_to_int = 0;
    endcase
  endfunction

endpackage

// File: rtl/ternary_add_compare_unit_full_adder_cell.sv
// Balanced-ternary full adder: a + b + cin = 3*cout + sum, all operands 2-bit trits.
// Purely combinational; never emits code 11.
module ternary_full_adder_cell
  import ternary_add_compare_unit_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] cin,
  output logic [1:0] sum,
  output logic [1:0] cout
);

  int total;

  always_comb begin
    total = trit_to_int(a) + trit_to_int(b) + trit_to_int(cin);
    sum   = TRIT_ZERO;
    cout  = TRIT_ZERO;
    case (total)
      3:  begin sum = TRIT_ZERO; cout = TRIT_POS; end
      2:  begin sum = TRIT_NEG;  cout = TRIT_POS; end
      1:  begin sum = TRIT_POS;  cout = TRIT_ZERO; end
      -1: begin sum = TRIT_NEG;  cout = TRIT_ZERO; end
      -2: begin sum = TRIT_POS;  cout = TRIT_NEG; end
      -3: begin sum = TRIT_ZERO; cout = TRIT_NEG; end
      default: begin sum = TRIT_ZERO; cout = TRIT_ZERO; end
    endcase
  end

endmodule

// File: rtl/ternary_add_compare_unit.sv
// Registered balanced-ternary ripple adder plus signed less-than compare; 1-cycle latency, enable is active-low (1 = hold).
// Optional registered overflow flag under `TERNARY_ADD_OVERFLOW_EN.
module ternary_add_compare_unit
  import ternary_add_compare_unit_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
)(
  input  logic                     clock,
  input  logic                     reset,
  input  logic [2*WORD_SIZE-1:0]   input1,
  input  logic [2*WORD_SIZE-1:0]   input2,
  input  logic                     enable,
  output logic [2*WORD_SIZE-1:0]   result,
  output logic                     less_than,
  output logic [1:0]               carry_out
`ifdef TERNARY_ADD_OVERFLOW_EN
  ,
  output logic                     overflow
`endif
);

  logic [2*WORD_SIZE+1:0] carry_chain;
  logic [2*WORD_SIZE-1:0] sum_next;
  logic                   less_next;
  logic                   decided;

  assign carry_chain[1:0] = TRIT_ZERO;

  for (genvar i = 0; i < WORD_SIZE; i++) begin : g_cell
    ternary_full_adder_cell u_cell (
      .a    (input1[2*i +: 2]),
      .b    (input2[2*i +: 2]),
      .cin  (carry_chain[2*i +: 2]),
      .sum  (sum_next[2*i +: 2]),
      .cout (carry_chain[2*(i+1) +: 2])
    );
  end

  // MSB-first scan: the first differing trit decides the ordering.
  always_comb begin
    less_next = 1'b0;
    decided   = 1'b0;
    for (int i = WORD_SIZE - 1; i >= 0; i--) begin
      if (!decided && (trit_to_int(input1[2*i +: 2]) != trit_to_int(input2[2*i +: 2]))) begin
        decided   = 1'b1;
        less_next = trit_to_int(input1[2*i +: 2]) < trit_to_int(input2[2*i +: 2]);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result    <= '0;
      carry_out <= TRIT_ZERO;
      less_than <= 1'b0;
    end else if (!enable) begin
      result    <= sum_next;
      carry_out <= carry_chain[2*WORD_SIZE +: 2];
      less_than <= less_next;
    end
  end

`ifdef TERNARY_ADD_OVERFLOW_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (!enable) begin
      overflow <= (carry_chain[2*WORD_SIZE +: 2] != TRIT_ZERO);
    end
  end
`endif

endmodule

// File: tb/tb_ternary_add_compare_unit.sv
// Directed-vector bench for ternary_add_compare_unit (WORD_SIZE = 9), expected values hand-computed.
module tb_ternary_add_compare_unit;

  localparam int W = 9;
  localparam logic [17:0] ALL_POS = 18'h15555;
  localparam logic [17:0] ALL_NEG = 18'h2AAAA;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [17:0]   input1 = '0;
  logic [17:0]   input2 = '0;
  logic          enable = 1'b1;
  logic [17:0]   result;
  logic          less_than;
  logic [1:0]    carry_out;
`ifdef TERNARY_ADD_OVERFLOW_EN
  logic          overflow;
`endif

  int checks = 0;
  int errors = 0;

  ternary_add_compare_unit #(.WORD_SIZE(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .input1    (input1),
    .input2    (input2),
    .enable    (enable),
    .result    (result),
    .less_than (less_than),
    .carry_out (carry_out)
`ifdef TERNARY_ADD_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Integer to packed balanced ternary (bench-side encoding of hand-picked values).
  function automatic logic [17:0] enc(input int value);
    int v;
    int r;
    logic [17:0] w;
    v = value;
    w = '0;
    for (int i = 0; i < W; i++) begin
      r = ((v % 3) + 3) % 3;
      if (r == 1) begin w[2*i +: 2] = 2'b01; v = (v - 1) / 3; end
      else if (r == 2) begin w[2*i +: 2] = 2'b10; v = (v + 1) / 3; end
      else begin v = v / 3; end
    end
    return w;
  endfunction

  task automatic apply(input logic [17:0] a, input logic [17:0] b);
    @(negedge clock);
    input1 = a;
    input2 = b;
    enable = 1'b0;
    @(posedge clock);
    #1;
    enable = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic [17:0] r, input logic [1:0] c, input logic lt);
    check({tag, ".result"}, 32'(result), 32'(r));
    check({tag, ".carry"}, 32'(carry_out), 32'(c));
    check({tag, ".lt"}, 32'(less_than), 32'(lt));
`ifdef TERNARY_ADD_OVERFLOW_EN
    check({tag, ".ovf"}, 32'(overflow), 32'(c != 2'b00));
`endif
  endtask

  initial begin
    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    expect_out("reset", '0, 2'b00, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    expect_out("reset_hold", '0, 2'b00, 1'b0);

    apply(enc(1), enc(1));
    check("inc_enc", 32'(result), 32'(18'b00_0000_0000_0000_0110));
    expect_out("inc", enc(2), 2'b00, 1'b0);

    apply(ALL_POS, enc(1));
    expect_out("wrap_max", ALL_NEG, 2'b01, 1'b0);

    apply(ALL_NEG, enc(-1));
    expect_out("wrap_min", ALL_POS, 2'b10, 1'b1);

    apply(ALL_NEG, ALL_POS);
    expect_out("cmp_min_max", '0, 2'b00, 1'b1);

    apply(enc(5), enc(5));
    expect_out("cmp_eq", enc(10), 2'b00, 1'b0);

    apply(enc(4), enc(5));
    expect_out("cmp_lsb", enc(9), 2'b00, 1'b1);

    apply(enc(7), enc(-20));
    expect_out("cmp_gt", enc(-13), 2'b00, 1'b0);

    // Hold: new operands with enable high must not disturb outputs
    apply(enc(3), enc(-1));
    expect_out("hold_load", enc(2), 2'b00, 1'b0);
    @(negedge clock);
    input1 = enc(-5);
    input2 = enc(7);
    enable = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    expect_out("hold", enc(2), 2'b00, 1'b0);

    // Invalid code 11 reads as zero
    apply(18'b11, '0);
    expect_out("invalid_zero", '0, 2'b00, 1'b0);
    apply(18'b11, enc(1));
    expect_out("invalid_lt", enc(1), 2'b00, 1'b1);

    // Reset wins over enable, then first enabled edge after release is valid
    apply(ALL_POS, enc(1));
    @(negedge clock);
    input1 = enc(100);
    input2 = enc(200);
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    expect_out("reset_async", '0, 2'b00, 1'b0);
    @(posedge clock);
    #1;
    expect_out("reset_wins", '0, 2'b00, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    enable = 1'b1;
    expect_out("post_reset", enc(300), 2'b00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
